ctx_switch: RTL and testbench
=============================

CTX_SWITCH -- requirements
Module: ctx_switch

Interface
REQ-001 Parameter CTX_W, default 256, packed context width (8 x 32-bit registers, reg0 in bits [255:224]).
REQ-002 Parameter SETTLE, default 2, cycles between core_done and the register snapshot.
REQ-003 Parameter CNT_W, default 16, run-cycle counter width.
REQ-004 clk  in  1  sole clock, all logic on posedge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 work_valid / work_ready  in / out  1 / 1  work-queue handshake.
REQ-007 work_data  in  CTX_W  initial register context.
REQ-008 writing_regs  out  1  register-file bulk-write enable.
REQ-009 change_me  out  CTX_W  bulk-write data to the register file.
REQ-010 core_start  out  1  one-cycle pulse that starts the thread.
REQ-011 core_done  in  1  thread-finished indication.
REQ-012 give_me  out  1  register-file snapshot request.
REQ-013 the_regs  in  CTX_W  register-file snapshot, one cycle behind the register contents.
REQ-014 result_valid / result_ready  out / in  1 / 1  result-queue handshake.
REQ-015 result_data  out  CTX_W  final register context.
REQ-016 result_cycles  out  CNT_W  RUN-state cycle count, saturating.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, LOAD, RUN, DRAIN, OUT.
REQ-019 work_ready SHALL be 1 only in IDLE.
REQ-020 IDLE with work_valid=1 SHALL capture work_data into change_me and move to LOAD.
REQ-021 LOAD SHALL last exactly 1 cycle with writing_regs=1, then go to RUN; writing_regs SHALL be 0 in all other states.
REQ-022 core_start SHALL be 1 only in the first RUN cycle.
REQ-023 In RUN the cycle counter SHALL increment each cycle, starting at 1 in the first RUN cycle, and saturate at 2^CNT_W-1.
REQ-024 core_done=1 in any RUN cycle, including the first, SHALL end RUN; that cycle is counted, and the next state is DRAIN.
REQ-025 core_done SHALL be ignored outside RUN.
REQ-026 DRAIN SHALL hold give_me=1 for exactly SETTLE cycles.
REQ-027 On the last DRAIN cycle the_regs SHALL be registered into result_data, and the state SHALL move to OUT.
REQ-028 In OUT, result_valid=1; result_data and result_cycles SHALL be stable until result_ready=1.
REQ-029 OUT with result_ready=1 SHALL complete the handshake and return to IDLE; a new work item is accepted no earlier than the following cycle.
REQ-030 result_cycles SHALL hold the final counter value while in OUT; the counter SHALL clear on IDLE->LOAD.
REQ-031 change_me SHALL hold its captured value until the next accepted work item.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE and clear the counter, change_me and result_data.
REQ-033 During reset, writing_regs, core_start, give_me, result_valid and busy SHALL be 0.
REQ-034 Reset in any state, including mid-RUN or mid-DRAIN, SHALL discard the in-flight item with no result emitted.
REQ-035 During reset and in the first cycle after it, work_ready SHALL be 0; it SHALL rise in the second cycle after reset is released.

Structure
REQ-036 A shared package gpu_pkg SHALL hold the state enum, CTX_W, REG_W=32, NREGS=8 and the reg0-at-MSB packing rule.
REQ-037 The saturating run counter SHALL be one sub-module, sat_counter (inputs clr and inc, parameter CNT_W).
REQ-038 The design SHALL contain no other sub-modules, one registered FSM, and no combinational path from core_done to any output.

Verification
REQ-039 Reset then one item, work_data = 32'h1..32'h8 packed, with core_done 5 cycles after core_start:
        -> writing_regs pulses once, change_me equals the input, result_cycles=6, result_data equals the_regs on the last DRAIN cycle.
REQ-040 core_done in the same cycle as core_start -> result_cycles=1 and DRAIN lasts exactly 2 cycles.
REQ-041 result_ready held low for 10 cycles in OUT -> result_valid, result_data and result_cycles stay constant, work_ready=0 throughout.
REQ-042 CNT_W=4 with a 20-cycle RUN -> result_cycles=15.
REQ-043 rst_n low for 1 cycle mid-RUN -> all outputs 0 and no result_valid; the next item completes normally.
REQ-044 work_valid held high over two back-to-back items -> the second is accepted the cycle after the first result handshake; the two results are distinct and in order.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the context-switch block: FSM states, context
// geometry and the reg0-at-MSB packing rule.
package gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam int CTX_W = 256;
  localparam int REG_W = 32;
  localparam int NREGS = 8;

  // Register idx occupies [reg_lsb(idx) +: REG_W]; reg0 sits in the top word.
  function automatic int reg_lsb(input int idx);
    return CTX_W - REG_W * (idx + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ctx_switch.sv
// Thread context switcher: loads a register context, runs the core, snapshots
// the register file after a settle window and hands the result downstream.
module ctx_switch #(
  parameter int CTX_W  = gpu_pkg::CTX_W,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  work_valid,
  output logic                  work_ready,
  input  logic [CTX_W-1:0]      work_data,
  output logic                  writing_regs,
  output logic [CTX_W-1:0]      change_me,
  output logic                  core_start,
  input  logic                  core_done,
  output logic                  give_me,
  input  logic [CTX_W-1:0]      the_regs,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [CTX_W-1:0]      result_data,
  output logic [CNT_W-1:0]      result_cycles,
  output logic                  busy,
  output gpu_pkg::state_t       dbg_state
);
  import gpu_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready is registered and never depends on valid in the same cycle.

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state_d, state_q;
  logic             rdy_en_d, rdy_en_q;
  logic             work_ready_d, work_ready_q;
  logic             writing_regs_d, writing_regs_q;
  logic             core_start_d, core_start_q;
  logic             give_me_d, give_me_q;
  logic             result_valid_d, result_valid_q;
  logic             busy_d, busy_q;
  logic [SW-1:0]    drain_d, drain_q;
  logic [CTX_W-1:0] change_me_d, change_me_q;
  logic [CTX_W-1:0] result_data_d, result_data_q;
  logic             cnt_clr, cnt_inc;

  always_comb begin
    state_d        = state_q;
    rdy_en_d       = 1'b1;
    writing_regs_d = 1'b0;
    core_start_d   = 1'b0;
    give_me_d      = 1'b0;
    result_valid_d = 1'b0;
    drain_d        = drain_q;
    change_me_d    = change_me_q;
    result_data_d  = result_data_q;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (work_ready_q && work_valid) begin
          state_d        = ST_LOAD;
          change_me_d    = work_data;
          writing_regs_d = 1'b1;
          cnt_clr        = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d      = ST_RUN;
        core_start_d = 1'b1;
      end
      ST_RUN: begin
        cnt_inc = 1'b1;
        if (core_done) begin
          state_d   = ST_DRAIN;
          give_me_d = 1'b1;
          drain_d   = '0;
        end
      end
      ST_DRAIN: begin
        // the_regs lags the register file, so sample only on the final cycle.
        if (drain_q == SW'(SETTLE - 1)) begin
          state_d        = ST_OUT;
          result_data_d  = the_regs;
          result_valid_d = 1'b1;
        end else begin
          give_me_d = 1'b1;
          drain_d   = drain_q + SW'(1);
        end
      end
      ST_OUT: begin
        result_valid_d = 1'b1;
        if (result_ready) begin
          state_d        = ST_IDLE;
          result_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    work_ready_d = rdy_en_q && (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rdy_en_q       <= 1'b0;
      work_ready_q   <= 1'b0;
      writing_regs_q <= 1'b0;
      core_start_q   <= 1'b0;
      give_me_q      <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      drain_q        <= '0;
      change_me_q    <= '0;
      result_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      rdy_en_q       <= rdy_en_d;
      work_ready_q   <= work_ready_d;
      writing_regs_q <= writing_regs_d;
      core_start_q   <= core_start_d;
      give_me_q      <= give_me_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      drain_q        <= drain_d;
      change_me_q    <= change_me_d;
      result_data_q  <= result_data_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (result_cycles)
  );

  assign work_ready   = work_ready_q;
  assign writing_regs = writing_regs_q;
  assign change_me    = change_me_q;
  assign core_start   = core_start_q;
  assign give_me      = give_me_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ctx_switch.sv
// Self-checking bench for ctx_switch: a default instance plus a CNT_W=4
// instance sharing the same stimulus to exercise counter saturation.
module tb_ctx_switch;
  import gpu_pkg::*;

  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         work_valid = 1'b0;
  logic [255:0] work_data = '0;
  logic         core_done = 1'b0;
  logic [255:0] the_regs = '0;
  logic         result_ready = 1'b0;

  logic         work_ready, writing_regs, core_start, give_me, result_valid, busy;
  logic [255:0] change_me, result_data;
  logic [15:0]  result_cycles;
  state_t       dbg_state;

  logic         s_work_ready, s_writing_regs, s_core_start, s_give_me, s_result_valid, s_busy;
  logic [255:0] s_change_me, s_result_data;
  logic [3:0]   s_result_cycles;
  state_t       s_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [255:0] exp_data_q[$];
  logic [255:0] exp_cyc_q[$];

  always #5 clk = ~clk;

  ctx_switch #(.CTX_W(256), .SETTLE(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .work_valid(work_valid), .work_ready(work_ready),
    .work_data(work_data), .writing_regs(writing_regs), .change_me(change_me),
    .core_start(core_start), .core_done(core_done), .give_me(give_me),
    .the_regs(the_regs), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_cycles(result_cycles), .busy(busy),
    .dbg_state(dbg_state)
  );

  ctx_switch #(.CTX_W(256), .SETTLE(SETTLE), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .work_valid(work_valid), .work_ready(s_work_ready),
    .work_data(work_data), .writing_regs(s_writing_regs), .change_me(s_change_me),
    .core_start(s_core_start), .core_done(core_done), .give_me(s_give_me),
    .the_regs(the_regs), .result_valid(s_result_valid), .result_ready(result_ready),
    .result_data(s_result_data), .result_cycles(s_result_cycles), .busy(s_busy),
    .dbg_state(s_dbg_state)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [255:0] mk_regs(input int c);
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < NREGS; r++) v[reg_lsb(r) +: 32] = {16'(c), 8'(r), 8'h5a};
    return v;
  endfunction

  function automatic logic [255:0] rand_ctx();
    logic [255:0] v;
    for (int r = 0; r < NREGS; r++) v[reg_lsb(r) +: 32] = $urandom;
    return v;
  endfunction

  // One cycle: outputs are observed after the falling edge; the_regs tracks cyc.
  task automatic step();
    @(negedge clk);
    cyc++;
    the_regs = mk_regs(cyc);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_wr"}, writing_regs, 0);
    check({tag, "_start"}, core_start, 0);
    check({tag, "_give"}, give_me, 0);
    check({tag, "_rvalid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, work_ready, 0);
    check({tag, "_chg"}, change_me, 0);
    check({tag, "_rdata"}, result_data, 0);
    check({tag, "_rcyc"}, result_cycles, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic run_item(input logic [255:0] data, input int done_after, input int ready_delay,
                          input bit keep_valid, input bit expect_immediate, input bit done_in_load);
    int n;
    logic [255:0] hold_d, hold_c, exp_c;
    work_data  = data;
    work_valid = 1'b1;
    n = 0;
    while (!work_ready && n < 20) begin step(); n++; end
    check("accept_wait", 32'(n < 20), 1);
    if (expect_immediate) check("b2b_accept", n, 0);
    step();
    check("load_wr", writing_regs, 1);
    check("load_chg", change_me, data);
    check("load_state", dbg_state, ST_LOAD);
    check("load_ready", work_ready, 0);
    work_valid = keep_valid;
    core_done  = done_in_load;
    step();
    core_done = 1'b0;
    check("run_start", core_start, 1);
    check("run_wr", writing_regs, 0);
    check("run_chg", change_me, data);
    for (int i = 0; i < done_after; i++) begin
      step();
      if (i == 0) check("start_pulse", core_start, 0);
    end
    core_done = 1'b1;
    exp_data_q.push_back(mk_regs(cyc + SETTLE));
    exp_cyc_q.push_back(256'(done_after + 1));
    step();
    core_done = 1'b0;
    n = 0;
    while (give_me && n < 10) begin n++; step(); end
    check("drain_len", n, SETTLE);
    check("out_valid", result_valid, 1);
    check("out_ready", work_ready, 0);
    hold_d = result_data;
    hold_c = 256'(result_cycles);
    for (int i = 0; i < ready_delay; i++) begin
      step();
      check("hold_valid", result_valid, 1);
      check("hold_data", result_data, hold_d);
      check("hold_cyc", result_cycles, hold_c);
      check("hold_ready", work_ready, 0);
    end
    result_ready = 1'b1;
    if (exp_data_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      exp_c = exp_cyc_q.pop_front();
      check("res_data", result_data, exp_data_q.pop_front());
      check("res_cycles", result_cycles, exp_c);
      check("res_cycles_sat4", s_result_cycles, (exp_c > 15) ? 256'd15 : exp_c);
    end
    step();
    result_ready = 1'b0;
    check("post_valid", result_valid, 0);
    check("post_busy", busy, 0);
    check("post_ready", work_ready, 1);
    check("post_chg", change_me, data);
  endtask

  initial begin
    logic [255:0] d, d2;
    repeat (3) step();
    check_reset_outs("rst");
    rst_n = 1'b1;
    step();
    check("rel1_ready", work_ready, 0);
    step();
    check("rel2_ready", work_ready, 1);

    d = '0;
    for (int r = 0; r < NREGS; r++) d[reg_lsb(r) +: 32] = 32'(r + 1);
    run_item(d, 5, 0, 1'b0, 1'b0, 1'b1);
    run_item(rand_ctx(), 0, 0, 1'b0, 1'b0, 1'b0);
    run_item(rand_ctx(), $urandom_range(1, 6), 10, 1'b0, 1'b0, 1'b0);
    run_item(rand_ctx(), 19, 0, 1'b0, 1'b0, 1'b0);

    // Abort an item mid-RUN with a one-cycle reset.
    work_data  = rand_ctx();
    work_valid = 1'b1;
    step();
    step();
    work_valid = 1'b0;
    repeat (3) step();
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    step();
    check_reset_outs("midrst");
    rst_n = 1'b1;
    step();
    check("mid_rel1_ready", work_ready, 0);
    check("mid_rel1_rvalid", result_valid, 0);
    step();
    check("mid_rel2_ready", work_ready, 1);
    run_item(rand_ctx(), $urandom_range(1, 8), 0, 1'b0, 1'b0, 1'b0);

    d  = rand_ctx();
    d2 = ~d;
    run_item(d, 3, 2, 1'b1, 1'b0, 1'b0);
    run_item(d2, 4, 0, 1'b0, 1'b1, 1'b0);
    check("sb_drained", exp_data_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
